regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Write-side initiator for the 32x32 register file. It drives the single regfile write port (ctrl_writeEnable/ctrl_writeReg/data_writeReg) from two sources:
- the pipeline writeback stage, which always completes in order;
- the multicycle mult/div unit, whose late results are buffered in a small FIFO.

It also keeps a pending-register scoreboard and produces the decode-stage stall for reads of registers with outstanding mult/div results.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
DEPTH, 2, mult/div result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, cycles a FIFO head may wait before it forces priority

Ports:
clock  in  1  single clock, rising edge
ctrl_reset_n  in  1  asynchronous, active-low reset
wb_valid  in  1  pipeline writeback request; held while wb_stall=1
wb_reg  in  ADDR_W  pipeline destination register
wb_data  in  DATA_W  pipeline result
wb_stall  out  1  pipeline writeback not taken this cycle; hold wb_*
md_issue  in  1  mult/div operation issued this cycle
md_issue_reg  in  ADDR_W  destination of issued op
md_valid  in  1  mult/div result available
md_reg  in  ADDR_W  result destination
md_data  in  DATA_W  result value
md_ready  out  1  FIFO accepts result (transfer = md_valid & md_ready)
rd_regA  in  ADDR_W  decode read address A
rd_regB  in  ADDR_W  decode read address B
rd_stall  out  1  A or B is pending
pending  out  2**ADDR_W  scoreboard bitmask
ctrl_writeEnable  out  1  regfile write enable (registered)
ctrl_writeReg  out  ADDR_W  regfile write index (registered)
data_writeReg  out  DATA_W  regfile write data (registered)

Behaviour:
Reset (ctrl_reset_n=0, asynchronous):
- ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
- pending=0, FIFO empty, age=0.
- wb_stall=0, rd_stall=0, md_ready=0 (md_ready gated by ctrl_reset_n).
- Reset mid-operation drops all FIFO contents and pending bits.

FIFO push:
- md_ready = ctrl_reset_n & (count<DEPTH).
- On a transfer, {md_reg, md_data} is pushed.
- No same-cycle pass-through: a full FIFO shows md_ready=0 even if it pops that cycle.

Age counter:
- Counts cycles the FIFO head has been non-empty and not popped.
- Cleared on pop or when the FIFO is empty; saturates at STARVE_LIMIT.

Priority, evaluated combinationally each cycle:
- force = (count>0) & (age>=STARVE_LIMIT). wb_stall = force & wb_valid.
- If wb_valid & !force: select pipeline.
- Else if count>0: pop head and select it.
- Else: no write.

Output register:
- On the next edge: ctrl_writeEnable = selected & (selected reg != 0); ctrl_writeReg and data_writeReg take the selected values.
- With no selection, ctrl_writeEnable=0; reg/data outputs hold their previous values.
- A selection targeting register 0 is consumed (popped or taken) with WE=0.

Latency:
- Pipeline request to regfile write: 1 cycle.
- Mult/div transfer to regfile write: 2 cycles minimum (push, then pop).

Scoreboard:
- md_issue & md_issue_reg!=0 sets pending[md_issue_reg].
- Popping entry r clears pending[r].
- Same-cycle set and clear of the same bit: set wins.
- Pipeline writes never touch pending.
- Upstream guarantees at most one outstanding op per register; a re-issue leaves the bit set.
- rd_stall = pending[rd_regA] | pending[rd_regB], combinational. Register 0 is never pending.

Decomposition:
- Package regfile_pkg: DATA_W, ADDR_W, NUM_REGS=32, ZERO_REG=0, typedef wb_entry_t {reg, data}.
- One sub-module, wb_fifo: DEPTH-entry synchronous FIFO of wb_entry_t with count, push/pop, same async active-low reset.
- Arbitration, age counter, scoreboard and output register live in the top level.

Test Plan:
1. Reset mid-stream: FIFO holding 2 entries, pending=0x0000_0060, assert ctrl_reset_n=0 -> all outputs 0 immediately; after release md_ready=1, pending=0, and no write occurs.
2. Pipeline only: wb_valid, wb_reg=5, wb_data=0xDEADBEEF -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF. Then wb_reg=0 -> ctrl_writeEnable=0.
3. Mult/div path: md_issue_reg=7 -> pending[7]=1, and rd_regA=7 gives rd_stall=1. Result md_reg=7, md_data=42 with pipeline idle -> write reg 7 two cycles after transfer; pending[7] clears at the pop edge.
4. Backpressure: pipeline busy, push 2 results -> md_ready=0. A third md_valid is held until a pop, and no result is lost or reordered.
5. Starvation: wb_valid=1 every cycle with the FIFO holding reg 9 -> after 4 waiting cycles, wb_stall=1 for exactly 1 cycle, reg 9 is written, and the held pipeline write follows next cycle.
6. Collision: md_issue_reg=3 in the same cycle that FIFO entry reg 3 pops -> pending[3] remains 1.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_pkg : shared widths and write-entry type for the regfile write side
// Revision    : 1.0
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_fifo  : DEPTH-entry synchronous FIFO of pending mult/div write entries
// Revision : 1.0
// ---------------------------------------------------------------------------
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_wb_arbiter : arbitrates pipeline and mult/div writes onto the regfile
// Revision           : 1.0
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W       = regfile_pkg::DATA_W,
  parameter int ADDR_W       = regfile_pkg::ADDR_W,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 ctrl_reset_n,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_reg,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 wb_stall,
  input  logic                 md_issue,
  input  logic [ADDR_W-1:0]    md_issue_reg,
  input  logic                 md_valid,
  input  logic [ADDR_W-1:0]    md_reg,
  input  logic [DATA_W-1:0]    md_data,
  output logic                 md_ready,
  input  logic [ADDR_W-1:0]    rd_regA,
  input  logic [ADDR_W-1:0]    rd_regB,
  output logic                 rd_stall,
  output logic [2**ADDR_W-1:0] pending,
  output logic                 ctrl_writeEnable,
  output logic [ADDR_W-1:0]    ctrl_writeReg,
  output logic [DATA_W-1:0]    data_writeReg
);

  import regfile_pkg::*;

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int AGE_W = $clog2(STARVE_LIMIT+1);

  logic [CNT_W-1:0]    count;
  wb_entry_t           head;
  wb_entry_t           push_entry;
  logic [AGE_W-1:0]    age;
  logic                fifo_nonempty;
  logic                force_md;
  logic                push;
  logic                pop;
  logic                sel_valid;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic [2**ADDR_W-1:0] pending_next;

  assign fifo_nonempty = (count != '0);
  assign md_ready      = ctrl_reset_n && (count < CNT_W'(DEPTH));
  assign push          = md_valid && md_ready;
  assign push_entry    = '{dst: md_reg, data: md_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clock),
    .rst_n      (ctrl_reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  // A starved head pre-empts the pipeline for one write.
  assign force_md = fifo_nonempty && (age >= AGE_W'(STARVE_LIMIT));
  assign wb_stall = force_md && wb_valid;

  always_comb begin
    sel_valid = 1'b0;
    sel_reg   = wb_reg;
    sel_data  = wb_data;
    pop       = 1'b0;
    if (wb_valid && !force_md) begin
      sel_valid = 1'b1;
    end else if (fifo_nonempty) begin
      sel_valid = 1'b1;
      pop       = 1'b1;
      sel_reg   = head.dst;
      sel_data  = head.data;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      age <= '0;
    end else if (pop || !fifo_nonempty) begin
      age <= '0;
    end else if (age < AGE_W'(STARVE_LIMIT)) begin
      age <= age + AGE_W'(1);
    end
  end

  // Issue is applied after the pop clear so a same-cycle re-issue keeps the bit.
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head.dst] = 1'b0;
    if (md_issue && (md_issue_reg != ZERO_REG)) pending_next[md_issue_reg] = 1'b1;
    pending_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) pending <= '0;
    else               pending <= pending_next;
  end

  assign rd_stall = pending[rd_regA] | pending[rd_regB];

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      ctrl_writeEnable <= sel_valid && (sel_reg != ZERO_REG);
      if (sel_valid) begin
        ctrl_writeReg <= sel_reg;
        data_writeReg <= sel_data;
      end
    end
  end

endmodule
`default_nettype wire
